// File: rtl/ram_pkg.sv
// Shared definitions for the 18Kb block RAM wrapper and its controllers:
// legal port shapes, depth derivation and a clog2 helper.
package ram_pkg;

    typedef struct packed {
        int unsigned aw;
        int unsigned dw;
    } ram_shape_t;

    // 7-series 18Kb native aspect ratios (address width vs widest data port)
    localparam int unsigned RAM18_SHAPE_COUNT = 6;
    localparam ram_shape_t RAM18_SHAPES [RAM18_SHAPE_COUNT] = '{
        '{aw: 14, dw: 1},
        '{aw: 13, dw: 2},
        '{aw: 12, dw: 4},
        '{aw: 11, dw: 9},
        '{aw: 10, dw: 18},
        '{aw: 9,  dw: 36}
    };

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    function automatic int unsigned ram_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    // Widest data port usable at a given address width (0 if too deep)
    function automatic int unsigned ram_max_width(input int unsigned aw);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < RAM18_SHAPE_COUNT; i++) begin
            if (aw <= RAM18_SHAPES[i].aw) w = RAM18_SHAPES[i].dw;
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry output buffer behind the RAM read port; the head register
// drives the consumer directly.
module fifo_out_buf
    import ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cap,
    input  logic signed [DATA_WIDTH-1:0] cap_data,
    input  logic                         pop,
    output logic signed [DATA_WIDTH-1:0] head,
    output logic                         valid,
    output logic [1:0]                   cnt
);

    logic signed [DATA_WIDTH-1:0] tail;

    assign valid = (cnt != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            head <= '0;
            tail <= '0;
        end else begin
            case (cnt)
                2'd0: begin
                    if (cap) begin
                        head <= cap_data;
                        cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (pop && cap) begin
                        head <= cap_data;
                    end else if (pop) begin
                        cnt <= 2'd0;
                    end else if (cap) begin
                        tail <= cap_data;
                        cnt  <= 2'd2;
                    end
                end
                default: begin
                    // Full buffer only accepts a capture alongside a pop
                    if (pop) begin
                        head <= tail;
                        if (cap) tail <= cap_data;
                        else     cnt  <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller over a true-dual-port 18Kb RAM: port 1 writes, port 2
// reads ahead into a 2-entry buffer so pops sustain one word per cycle.
module ram_fifo_ctrl
    import ram_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 7,
    parameter int unsigned DATA_WIDTH    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    output logic                         full,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic signed [DATA_WIDTH-1:0] rd_data,
    output logic [ADDRESS_WIDTH+1:0]     level,
    output logic                         ram_en1,
    output logic                         ram_we1,
    output logic [ADDRESS_WIDTH-1:0]     ram_addr1,
    output logic [DATA_WIDTH-1:0]        ram_di1,
    output logic                         ram_en2,
    output logic [ADDRESS_WIDTH-1:0]     ram_addr2,
    input  logic signed [DATA_WIDTH-1:0] ram_do2
);

    localparam int unsigned DEPTH = ram_depth(ADDRESS_WIDTH);
    localparam int unsigned PW    = ADDRESS_WIDTH + 1;
    localparam int unsigned LW    = ADDRESS_WIDTH + 2;

    logic [PW-1:0] wptr, rptr, ram_cnt;
    logic [1:0]    buf_cnt;
    logic          inflight;
    logic          push, pop, issue;

    assign ram_cnt = wptr - rptr;
    assign full    = (ram_cnt == PW'(DEPTH));
    assign push    = wr_en && !full;
    assign pop     = rd_valid && rd_ready;

    // Read ahead only while buffer plus in-flight word leaves a free slot
    assign issue = (ram_cnt != '0) &&
                   ((3'({1'b0, buf_cnt}) + 3'(inflight)) < (3'd2 + 3'(pop)));

    assign ram_en1   = push;
    assign ram_we1   = push;
    assign ram_addr1 = wptr[ADDRESS_WIDTH-1:0];
    assign ram_di1   = wr_data;
    assign ram_en2   = issue;
    assign ram_addr2 = rptr[ADDRESS_WIDTH-1:0];

    assign level = LW'(ram_cnt) + LW'(inflight) + LW'(buf_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            inflight <= 1'b0;
        end else begin
            if (push)  wptr <= wptr + PW'(1);
            if (issue) rptr <= rptr + PW'(1);
            inflight <= issue;
        end
    end

    fifo_out_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_buf (
        .clk      (clk),
        .rst      (rst),
        .cap      (inflight),
        .cap_data (ram_do2),
        .pop      (pop),
        .head     (rd_data),
        .valid    (rd_valid),
        .cnt      (buf_cnt)
    );

endmodule
